// File: rtl/cpu_perf_pkg.sv
// Shared encodings for the pipeline event monitor: read-select codes and FSM states.
`timescale 1ns/100ps
package cpu_perf_pkg;

  localparam logic [2:0] SEL_CYCLE  = 3'd0;
  localparam logic [2:0] SEL_STALL  = 3'd1;
  localparam logic [2:0] SEL_FLUSH  = 3'd2;
  localparam logic [2:0] SEL_RETIRE = 3'd3;
  localparam logic [2:0] SEL_HALTPC = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
`timescale 1ns/100ps
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_event_counter.sv
// Event monitor beside the MIPS pipeline: counts cycles, load-use stalls, flushes and
// retirements while the CPU runs, halting after a fixed cycle budget and latching the PC there.
`timescale 1ns/100ps
module pipeline_event_counter
  import cpu_perf_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic [31:0]      pc_i,
  input  logic             clear_i,
  input  logic [2:0]       sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             halted_o,
  output logic             busy_o,
  output state_t           dbg_state_o
);

  generate
    if (MAX_CYCLES < 1) begin : g_bad_max_cycles
      $error("pipeline_event_counter: MAX_CYCLES must be at least 1");
    end
  endgenerate

  // The budget runs on its own non-saturating counter so a narrow CNT_W cannot stall the halt.
  localparam int            BW   = $clog2(MAX_CYCLES + 1);
  localparam logic [BW-1:0] LAST = BW'(MAX_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic             halted_d;
  logic             busy_d;
  logic             count_en;
  logic             halt_edge;
  logic [BW-1:0]    budget;
  logic [31:0]      halt_pc;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] retire_cnt;

  assign count_en  = (state == ST_COUNT) && start_i && !clear_i;
  assign halt_edge = count_en && (budget == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      halted_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state    <= next_state;
      halted_o <= halted_d;
      busy_o   <= busy_d;
    end
  end

  always_comb begin
    next_state = state;
    if (clear_i) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start_i) next_state = ST_COUNT;
        ST_COUNT: begin
          if (!start_i)       next_state = ST_IDLE;
          else if (halt_edge) next_state = ST_HALTED;
        end
        ST_HALTED: next_state = ST_HALTED;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // Status flags are decoded from the next state so they line up with the state register.
  always_comb begin
    halted_d = (next_state == ST_HALTED);
    busy_d   = (next_state == ST_COUNT);
  end

  assign dbg_state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      budget  <= '0;
      halt_pc <= '0;
    end else if (clear_i) begin
      budget  <= '0;
      halt_pc <= '0;
    end else begin
      if (count_en)  budget  <= budget + BW'(1);
      if (halt_edge) halt_pc <= pc_i;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (clear_i),
    .inc_i (count_en), .cnt_o (cycle_cnt)
  );

  // A stall raised alongside a jump or branch is a control hazard, not a load-use stall.
  sat_counter #(.W(CNT_W)) u_stall (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (clear_i),
    .inc_i (count_en && stall_i && !jump_i && !branch_i), .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (clear_i),
    .inc_i (count_en && flush_i), .cnt_o (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (clear_i),
    .inc_i (count_en && retire_i), .cnt_o (retire_cnt)
  );

  always_comb begin
    rd_data_o = '0;
    case (sel_i)
      SEL_CYCLE:  rd_data_o = cycle_cnt;
      SEL_STALL:  rd_data_o = stall_cnt;
      SEL_FLUSH:  rd_data_o = flush_cnt;
      SEL_RETIRE: rd_data_o = retire_cnt;
      SEL_HALTPC: rd_data_o = CNT_W'(halt_pc);
      default:    rd_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_pipeline_event_counter.sv
// Bench for pipeline_event_counter: default instance for the main scenarios, a narrow
// 4-bit instance for saturation against a 40-cycle budget.
`timescale 1ns/100ps
module tb_pipeline_event_counter;
  import cpu_perf_pkg::*;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stall, jump, branch, flush, retire, clear;
  logic [31:0] pc;
  logic [2:0]  sel;
  logic [31:0] rd_data;
  logic        halted, busy;
  state_t      dbg_state;

  logic        rst2, start2, retire2, zero;
  logic [31:0] pc2;
  logic [2:0]  sel2;
  logic [3:0]  rd_data2;
  logic        halted2, busy2;
  state_t      dbg_state2;

  pipeline_event_counter #(.CNT_W(32), .MAX_CYCLES(30)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .jump_i(jump),
    .branch_i(branch), .flush_i(flush), .retire_i(retire), .pc_i(pc),
    .clear_i(clear), .sel_i(sel), .rd_data_o(rd_data), .halted_o(halted),
    .busy_o(busy), .dbg_state_o(dbg_state)
  );

  pipeline_event_counter #(.CNT_W(4), .MAX_CYCLES(40)) dut_narrow (
    .clk_i(clk), .rst_i(rst2), .start_i(start2), .stall_i(zero), .jump_i(zero),
    .branch_i(zero), .flush_i(zero), .retire_i(retire2), .pc_i(pc2),
    .clear_i(zero), .sel_i(sel2), .rd_data_o(rd_data2), .halted_o(halted2),
    .busy_o(busy2), .dbg_state_o(dbg_state2)
  );

  logic [31:0] exp_q[$];
  logic [31:0] obs [0:4];
  logic [31:0] exp_v;
  int          checks = 0;
  int          passed = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_all;
    for (int i = 0; i < 5; i++) begin
      sel = 3'(i);
      #0.5;
      obs[i] = rd_data;
    end
    sel = 3'd0;
  endtask

  task automatic push_counts(input logic [31:0] c, input logic [31:0] s, input logic [31:0] f,
                             input logic [31:0] r, input logic [31:0] p);
    exp_q.push_back(c);
    exp_q.push_back(s);
    exp_q.push_back(f);
    exp_q.push_back(r);
    exp_q.push_back(p);
  endtask

  task automatic test_reset;
    tick;
    tick;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #0.5;
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_data !== exp_v) $display("FAIL reset sel%0d: got %0d want %0d", i, rd_data, exp_v);
      else passed++;
    end
    sel = 3'd0;
    checks++;
    if ({halted, busy} !== 2'b00 || dbg_state !== ST_IDLE)
      $display("FAIL reset flags: got halted=%b busy=%b state=%0d want 0 0 0", halted, busy, dbg_state);
    else passed++;
  endtask

  task automatic test_budget;
    rst   = 1'b0;
    start = 1'b1;
    pc    = BASE;
    tick;
    push_counts(0, 0, 0, 0, 0);
    read_all;
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs[i] !== exp_v) $display("FAIL budget_entry sel%0d: got %0d want %0d", i, obs[i], exp_v);
      else passed++;
    end
    checks++;
    if ({halted, busy} !== 2'b01) $display("FAIL budget_entry flags: got halted=%b busy=%b want 0 1", halted, busy);
    else passed++;
    for (int k = 1; k <= 30; k++) begin
      pc = BASE + 32'(4 * k);
      tick;
      if (k == 29) begin
        checks++;
        if ({halted, busy} !== 2'b01) $display("FAIL budget_pre flags: got halted=%b busy=%b want 0 1", halted, busy);
        else passed++;
      end
    end
    push_counts(30, 0, 0, 0, BASE + 32'd120);
    read_all;
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs[i] !== exp_v) $display("FAIL budget_halt sel%0d: got %0h want %0h", i, obs[i], exp_v);
      else passed++;
    end
    checks++;
    if ({halted, busy} !== 2'b10 || dbg_state !== ST_HALTED)
      $display("FAIL budget_halt flags: got halted=%b busy=%b state=%0d want 1 0 2", halted, busy, dbg_state);
    else passed++;
    pc    = 32'hDEAD_BEEF;
    stall = 1'b1;
    flush = 1'b1;
    tick;
    tick;
    stall = 1'b0;
    flush = 1'b0;
    push_counts(30, 0, 0, 0, BASE + 32'd120);
    read_all;
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs[i] !== exp_v) $display("FAIL halted_sticky sel%0d: got %0h want %0h", i, obs[i], exp_v);
      else passed++;
    end
    checks++;
    if (halted !== 1'b1) $display("FAIL halted_sticky flag: got %b want 1", halted);
    else passed++;
  endtask

  task automatic test_clear;
    clear = 1'b1;
    tick;
    push_counts(0, 0, 0, 0, 0);
    read_all;
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs[i] !== exp_v) $display("FAIL clear sel%0d: got %0h want %0h", i, obs[i], exp_v);
      else passed++;
    end
    checks++;
    if ({halted, busy} !== 2'b00 || dbg_state !== ST_IDLE)
      $display("FAIL clear flags: got halted=%b busy=%b state=%0d want 0 0 0", halted, busy, dbg_state);
    else passed++;
    clear = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b1 || dbg_state !== ST_COUNT)
      $display("FAIL clear_restart: got busy=%b state=%0d want 1 1", busy, dbg_state);
    else passed++;
    sel = SEL_CYCLE;
    #0.5;
    checks++;
    if (rd_data !== 32'd0) $display("FAIL clear_restart cycle: got %0d want 0", rd_data);
    else passed++;
  endtask

  task automatic test_stall_mask;
    stall = 1'b1;
    repeat (3) tick;
    branch = 1'b1;
    repeat (2) tick;
    branch = 1'b0;
    jump   = 1'b1;
    tick;
    stall = 1'b0;
    jump  = 1'b0;
    push_counts(6, 3, 0, 0, 0);
    read_all;
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs[i] !== exp_v) $display("FAIL stall_mask sel%0d: got %0d want %0d", i, obs[i], exp_v);
      else passed++;
    end
  endtask

  task automatic test_same_edge;
    stall  = 1'b1;
    flush  = 1'b1;
    retire = 1'b1;
    tick;
    stall  = 1'b0;
    flush  = 1'b0;
    retire = 1'b0;
    push_counts(7, 4, 1, 1, 0);
    read_all;
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs[i] !== exp_v) $display("FAIL same_edge sel%0d: got %0d want %0d", i, obs[i], exp_v);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] c, s, f, r;
    c = 7; s = 4; f = 1; r = 1;
    for (int k = 0; k < 12; k++) begin
      stall  = 1'($urandom_range(0, 1));
      jump   = 1'($urandom_range(0, 1));
      branch = 1'($urandom_range(0, 1));
      flush  = 1'($urandom_range(0, 1));
      retire = 1'($urandom_range(0, 1));
      c = c + 1;
      if (stall && !jump && !branch) s = s + 1;
      if (flush)  f = f + 1;
      if (retire) r = r + 1;
      tick;
    end
    push_counts(c, s, f, r, 0);
    // Events while the CPU is stopped and on the re-entry edge must not count.
    stall = 1'b1; jump = 1'b0; branch = 1'b0; flush = 1'b1; retire = 1'b1;
    start = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE)
      $display("FAIL start_drop: got busy=%b state=%0d want 0 0", busy, dbg_state);
    else passed++;
    tick;
    start = 1'b1;
    tick;
    stall = 1'b0; flush = 1'b0; retire = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL start_resume: got busy=%b want 1", busy);
    else passed++;
    read_all;
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs[i] !== exp_v) $display("FAIL back_to_back sel%0d: got %0d want %0d", i, obs[i], exp_v);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    tick;
    repeat (12) tick;
    sel = SEL_CYCLE;
    #0.5;
    checks++;
    if (rd_data !== 32'd12) $display("FAIL reset_mid pre: got %0d want 12", rd_data);
    else passed++;
    rst = 1'b1;
    #0.5;
    push_counts(0, 0, 0, 0, 0);
    read_all;
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs[i] !== exp_v) $display("FAIL reset_mid sel%0d: got %0d want %0d", i, obs[i], exp_v);
      else passed++;
    end
    checks++;
    if ({halted, busy} !== 2'b00) $display("FAIL reset_mid flags: got halted=%b busy=%b want 0 0", halted, busy);
    else passed++;
    rst = 1'b0;
    tick;
    tick;
    push_counts(1, 0, 0, 0, 0);
    read_all;
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs[i] !== exp_v) $display("FAIL reset_restart sel%0d: got %0d want %0d", i, obs[i], exp_v);
      else passed++;
    end
  endtask

  task automatic test_saturation;
    rst2    = 1'b0;
    start2  = 1'b1;
    retire2 = 1'b1;
    pc2     = 32'h0000_1230;
    tick;
    for (int k = 1; k <= 40; k++) begin
      pc2 = 32'h0000_1230 + 32'(k);
      tick;
      if (k == 15 || k == 20) begin
        exp_q.push_back(32'd15);
        sel2 = SEL_RETIRE;
        #0.5;
        exp_v = exp_q.pop_front();
        checks++;
        if ({28'd0, rd_data2} !== exp_v) $display("FAIL sat_retire k%0d: got %0d want %0d", k, rd_data2, exp_v);
        else passed++;
      end
      if (k == 39) begin
        checks++;
        if ({halted2, busy2} !== 2'b01) $display("FAIL sat_pre_halt: got halted=%b busy=%b want 0 1", halted2, busy2);
        else passed++;
      end
    end
    checks++;
    if ({halted2, busy2} !== 2'b10 || dbg_state2 !== ST_HALTED)
      $display("FAIL sat_halt: got halted=%b busy=%b state=%0d want 1 0 2", halted2, busy2, dbg_state2);
    else passed++;
    exp_q.push_back(32'd15);
    exp_q.push_back(32'd15);
    exp_q.push_back(32'h8);
    sel2 = SEL_CYCLE;
    #0.5;
    exp_v = exp_q.pop_front();
    checks++;
    if ({28'd0, rd_data2} !== exp_v) $display("FAIL sat_cycle: got %0d want %0d", rd_data2, exp_v);
    else passed++;
    sel2 = SEL_RETIRE;
    #0.5;
    exp_v = exp_q.pop_front();
    checks++;
    if ({28'd0, rd_data2} !== exp_v) $display("FAIL sat_retire_end: got %0d want %0d", rd_data2, exp_v);
    else passed++;
    sel2 = SEL_HALTPC;
    #0.5;
    exp_v = exp_q.pop_front();
    checks++;
    if ({28'd0, rd_data2} !== exp_v) $display("FAIL sat_haltpc: got %0h want %0h", rd_data2, exp_v);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0;
    flush = 1'b0; retire = 1'b0; clear = 1'b0; pc = '0; sel = '0;
    rst2 = 1'b1; start2 = 1'b0; retire2 = 1'b0; zero = 1'b0; pc2 = '0; sel2 = '0;
    test_reset;
    test_budget;
    test_clear;
    test_stall_mask;
    test_same_edge;
    test_back_to_back;
    test_reset_mid;
    test_saturation;
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
